// File: rtl/spi_chk_pkg.sv
// Shared types and constants for the SPI-slave frame checker.
package spi_chk_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_CHK_RXV,
      S_WAIT_TX,
      S_SEND,
      S_END
   } state_e;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam int ERR_RESET         = 0;
   localparam int ERR_RXV_EARLY     = 1;
   localparam int ERR_RXV_MISSING   = 2;
   localparam int ERR_RX_DATA       = 3;
   localparam int ERR_MISO          = 4;
   localparam int ERR_TX_TIMEOUT    = 5;
   localparam int ERR_ABORT         = 6;
   localparam int ERR_FRAME_TIMEOUT = 7;
   localparam int NUM_ERR           = 8;

endpackage

// File: rtl/spi_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module spi_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)                    cnt_d = '0;
      else if (inc && cnt_q != '1) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/spi_slave_frame_checker.sv
// Passive SPI-slave checker: rebuilds each frame from SS_n/MOSI and checks the
// slave's rx strobe/word, MISO read data, aborts and timeouts.
module spi_slave_frame_checker
   import spi_chk_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int RXV_LAT    = 1,
   parameter int TX_TIMEOUT = 16,
   parameter int MAX_FRAME  = 64,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                clr_cnt,
   input  logic                dut_rst_n,
   input  logic                SS_n,
   input  logic                MOSI,
   input  logic                MISO,
   input  logic                rx_valid,
   input  logic [DATA_W+1:0]   rx_data,
   input  logic                tx_valid,
   input  logic [DATA_W-1:0]   tx_data,
   output logic                busy,
   output logic [NUM_ERR-1:0]  err_vec,
   output logic                err_pulse,
   output logic [CNT_W-1:0]    err_cnt,
   output logic [4*CNT_W-1:0]  frame_cnt
);

   localparam int RXW   = DATA_W + 2;
   localparam int CHK_C = DATA_W + 3 + RXV_LAT;
   localparam int CW    = $clog2(MAX_FRAME + 2);
   localparam int TW    = $clog2(TX_TIMEOUT + 1);
   localparam int BW    = $clog2(DATA_W + 1);

   state_e               state_q, state_d;
   logic [CW-1:0]        c_q, c_d;
   logic [RXW-1:0]       expect_q, expect_d;
   logic [DATA_W-1:0]    tx_q, tx_d;
   logic [TW-1:0]        tw_q, tw_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 frame_err_q, frame_err_d;
   logic                 ss_prev_q, rst_seen_q, err_pulse_q;
   logic [NUM_ERR-1:0]   err_vec_q, err_vec_d, err_now, err_fire;
   logic                 good_inc;
   logic [1:0]           cmd;

   assign cmd = expect_q[RXW-1 -: 2];

   always_comb begin
      state_d     = state_q;
      c_d         = c_q;
      expect_d    = expect_q;
      tx_d        = tx_q;
      tw_d        = tw_q;
      bit_d       = bit_q;
      frame_err_d = frame_err_q;
      err_now     = '0;
      good_inc    = 1'b0;
      if (en) err_now[ERR_RESET] = rst_seen_q & (rx_valid | (|rx_data) | MISO);

      if (!en || !dut_rst_n) begin
         state_d = S_IDLE;
      end else if (state_q == S_IDLE) begin
         if (!SS_n && ss_prev_q) begin
            state_d     = S_SHIFT;
            c_d         = CW'(1);
            frame_err_d = |err_now;
         end
      end else begin
         c_d = (c_q == CW'(MAX_FRAME + 1)) ? c_q : c_q + 1'b1;
         if (SS_n && state_q != S_END) begin
            err_now[ERR_ABORT] = 1'b1;
            state_d            = S_IDLE;
         end else begin
            case (state_q)
               S_SHIFT: begin
                  if (rx_valid) err_now[ERR_RXV_EARLY] = 1'b1;
                  // c=1 carries the op bit, which is not part of the rx word
                  if (c_q != CW'(1)) expect_d = {expect_q[RXW-2:0], MOSI};
                  if (c_q == CW'(DATA_W + 3)) state_d = S_CHK_RXV;
               end
               S_CHK_RXV: begin
                  if (c_q == CW'(CHK_C)) begin
                     if (!rx_valid)                err_now[ERR_RXV_MISSING] = 1'b1;
                     else if (rx_data != expect_q) err_now[ERR_RX_DATA]     = 1'b1;
                     tw_d    = '0;
                     bit_d   = '0;
                     state_d = (cmd == CMD_RD_DATA) ? S_WAIT_TX : S_END;
                  end else if (rx_valid) begin
                     err_now[ERR_RXV_EARLY] = 1'b1;
                  end
               end
               S_WAIT_TX: begin
                  if (rx_valid) err_now[ERR_RXV_EARLY] = 1'b1;
                  if (tx_valid) begin
                     tx_d    = tx_data;
                     state_d = S_SEND;
                  end else if (tw_q == TW'(TX_TIMEOUT - 1)) begin
                     err_now[ERR_TX_TIMEOUT] = 1'b1;
                     state_d                 = S_END;
                  end else begin
                     tw_d = tw_q + 1'b1;
                  end
               end
               S_SEND: begin
                  if (rx_valid) err_now[ERR_RXV_EARLY] = 1'b1;
                  if (MISO != tx_q[DATA_W-1]) err_now[ERR_MISO] = 1'b1;
                  tx_d  = tx_q << 1;
                  bit_d = bit_q + 1'b1;
                  if (bit_q == BW'(DATA_W - 1)) state_d = S_END;
               end
               S_END: begin
                  if (rx_valid) err_now[ERR_RXV_EARLY] = 1'b1;
                  if (SS_n) begin
                     state_d  = S_IDLE;
                     good_inc = ~(frame_err_q | (|err_now));
                  end
               end
               default: state_d = S_IDLE;
            endcase
            if (!SS_n && c_q == CW'(MAX_FRAME)) begin
               err_now[ERR_FRAME_TIMEOUT] = 1'b1;
               state_d                    = S_END;
            end
         end
         frame_err_d = frame_err_q | (|err_now);
      end

      err_fire  = clr_cnt ? '0 : err_now;
      err_vec_d = clr_cnt ? '0 : (err_vec_q | err_now);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         c_q         <= '0;
         expect_q    <= '0;
         tx_q        <= '0;
         tw_q        <= '0;
         bit_q       <= '0;
         frame_err_q <= 1'b0;
         ss_prev_q   <= 1'b0;
         rst_seen_q  <= 1'b0;
         err_vec_q   <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         expect_q    <= expect_d;
         tx_q        <= tx_d;
         tw_q        <= tw_d;
         bit_q       <= bit_d;
         frame_err_q <= frame_err_d;
         ss_prev_q   <= SS_n;
         rst_seen_q  <= ~dut_rst_n;
         err_vec_q   <= err_vec_d;
         err_pulse_q <= |err_fire;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_frame
      spi_sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
         .clk (clk),
         .rst (rst),
         .clr (clr_cnt),
         .inc (good_inc && cmd == 2'(i)),
         .cnt (frame_cnt[i*CNT_W +: CNT_W])
      );
   end

   spi_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr_cnt),
      .inc (|err_fire),
      .cnt (err_cnt)
   );

   assign busy      = (state_q != S_IDLE);
   assign err_vec   = err_vec_q;
   assign err_pulse = err_pulse_q;

endmodule
